// File: rtl/alu_pkg.sv
// Shared opcode/state types and the multi-cycle classifier for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpLsh  = 4'h1,
    OpRsh  = 4'h2,
    OpMov  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpAnd  = 4'h6,
    OpAddi = 4'h7,
    OpMul  = 4'h8,
    OpShln = 4'h9,
    OpShrn = 4'hA,
    OpNop  = 4'hF
  } alu_op_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_t;

  localparam alu_op_t OP_MUL  = OpMul;
  localparam alu_op_t OP_SHLN = OpShln;
  localparam alu_op_t OP_SHRN = OpShrn;

  // n is the already-clamped shift distance; a zero-distance shift completes in one cycle.
  function automatic logic is_multicycle(input logic [3:0] op, input int unsigned n);
    return (op == OP_MUL) || (((op == OP_SHLN) || (op == OP_SHRN)) && (n != 0));
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the controller (master) and seq_alu (slave).
interface seq_alu_if #(
  parameter int unsigned W = 8
) ();
  logic         start;
  logic [3:0]   cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         sc_i;
  logic         busy;
  logic         done;
  logic [W-1:0] rslt;
  logic [W-1:0] rslt_hi;
  logic         sc_o;
  logic         zero;
  logic         pari;

  modport master (
    output start, cmd, inA, inB, sc_i,
    input  busy, done, rslt, rslt_hi, sc_o, zero, pari
  );

  modport slave (
    input  start, cmd, inA, inB, sc_i,
    output busy, done, rslt, rslt_hi, sc_o, zero, pari
  );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational single-cycle operations; produces {sc, rslt} for every opcode.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [3:0]   i_cmd,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sc,
  output logic [W-1:0] o_rslt,
  output logic         o_sc
);

  always_comb begin
    o_rslt = '0;
    o_sc   = 1'b0;
    case (i_cmd)
      OpAdd, OpAddi: {o_sc, o_rslt} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_sc};
      OpLsh:         {o_sc, o_rslt} = {i_a, i_sc};
      OpRsh:         {o_rslt, o_sc} = {i_sc, i_a};
      // Zero-distance shifts land here as a plain pass-through.
      OpMov, OpNop, OpShln, OpShrn: o_rslt = i_a;
      OpOr:          o_rslt = i_a | i_b;
      OpXor:         o_rslt = i_a ^ i_b;
      OpAnd:         o_rslt = i_a & i_b;
      default:       ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops via alu_comb_core, shift-add MUL and bit-serial shifts.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = $clog2(W) + 1
) (
  input logic       clk,
  input logic       reset,
  seq_alu_if.slave  bus
);

  localparam logic [CNT_W-1:0] WCnt = CNT_W'(W);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_n;
  logic [2*W-1:0]   r_acc, w_mul_nxt;
  logic [W:0]       w_add;
  logic [W-1:0]     r_mcand, w_sh_nxt, w_core_rslt, w_fin_lo, w_fin_hi;
  logic             r_is_mul, r_is_left, r_full, r_first;
  logic             w_sh_sc, w_core_sc, w_fin_sc, w_multi, w_accept, w_last, w_update;
  logic             r_done, r_sc_o, r_zero, r_pari;
  logic [W-1:0]     r_rslt, r_rslt_hi;

  alu_comb_core #(.W(W)) u_core (
    .i_cmd  (bus.cmd),
    .i_a    (bus.inA),
    .i_b    (bus.inB),
    .i_sc   (bus.sc_i),
    .o_rslt (w_core_rslt),
    .o_sc   (w_core_sc)
  );

  assign w_n     = (bus.inB[CNT_W-1:0] > WCnt) ? WCnt : bus.inB[CNT_W-1:0];
  assign w_multi = is_multicycle(bus.cmd, 32'(w_n));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (w_multi) w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_update = (w_accept && !w_multi) || w_last;

  // Shift-add step: multiplier sits in the low half of r_acc, product grows from the top.
  assign w_add     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_add, r_acc[W-1:1]};

  always_comb begin
    w_sh_sc  = r_is_left ? r_acc[W-1] : r_acc[0];
    w_sh_nxt = r_is_left ? {r_acc[W-2:0], 1'b0} : {1'b0, r_acc[W-1:1]};
    w_fin_hi = '0;
    w_fin_lo = w_core_rslt;
    w_fin_sc = w_core_sc;
    if (r_state == StRun) begin
      if (r_is_mul) begin
        {w_fin_hi, w_fin_lo} = w_mul_nxt;
        w_fin_sc             = 1'b0;
      end else begin
        w_fin_lo = w_sh_nxt;
        // A full-width shift reports the first bit out rather than the last.
        w_fin_sc = r_full ? r_first : w_sh_sc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_is_mul  <= 1'b0;
      r_is_left <= 1'b0;
      r_full    <= 1'b0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
      r_rslt    <= '0;
      r_rslt_hi <= '0;
      r_sc_o    <= 1'b0;
      r_zero    <= 1'b0;
      r_pari    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_update;
      if (w_accept && w_multi) begin
        r_mcand   <= bus.inA;
        r_is_mul  <= (bus.cmd == OP_MUL);
        r_is_left <= (bus.cmd == OP_SHLN);
        r_cnt     <= (bus.cmd == OP_MUL) ? WCnt : w_n;
        r_acc     <= {{W{1'b0}}, (bus.cmd == OP_MUL) ? bus.inB : bus.inA};
        r_full    <= (w_n == WCnt);
        r_first   <= (bus.cmd == OP_SHLN) ? bus.inA[W-1] : bus.inA[0];
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= r_is_mul ? w_mul_nxt : {{W{1'b0}}, w_sh_nxt};
      end
      if (w_update) begin
        r_rslt    <= w_fin_lo;
        r_rslt_hi <= w_fin_hi;
        r_sc_o    <= w_fin_sc;
        r_zero    <= ({w_fin_hi, w_fin_lo} == '0);
        r_pari    <= ^w_fin_lo;
      end
    end
  end

  assign bus.busy    = (r_state == StRun);
  assign bus.done    = r_done;
  assign bus.rslt    = r_rslt;
  assign bus.rslt_hi = r_rslt_hi;
  assign bus.sc_o    = r_sc_o;
  assign bus.zero    = r_zero;
  assign bus.pari    = r_pari;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle 8-bit ALU in the datapath.
- Adds operand width W, registered result and flags, and a start/done handshake.
- Adds multi-cycle unsigned multiply (shift-add) and variable-distance shifts (one bit per cycle).
- Sits between the register file and the writeback mux; the controller holds writeback until done.

Parameters:
W, 8, operand/result width in bits (>=4)
CNT_W, $clog2(W)+1, width of shift-distance/iteration counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
cmd  in  4  operation code (alu_pkg::alu_op_t)
inA  in  W  operand A
inB  in  W  operand B; low CNT_W bits = shift distance for SHLN/SHRN
sc_i  in  1  carry/shift-in, sampled with start
busy  out  1  multi-cycle operation in progress
done  out  1  one-cycle pulse: rslt/flags updated this cycle
rslt  out  W  result (low half of product for MUL)
rslt_hi  out  W  high half of product for MUL; 0 for all other ops
sc_o  out  1  registered carry/shift-out
zero  out  1  registered: full result (rslt_hi,rslt) == 0
pari  out  1  registered: ^rslt

Behaviour:
- Reset (synchronous, active-high) wins over everything. State=IDLE; busy, done, rslt, rslt_hi, sc_o, zero, pari all 0. Aborts any in-flight op with no done.
- States: IDLE, RUN. busy = (state==RUN).
- start while busy=1 is ignored; operands are not resampled.
- Single-cycle ops (start sampled at edge k; results, flags and done=1 visible after edge k):
  - ADD 0000: {sc_o,rslt} = inA+inB+sc_i, computed W+1 bits wide.
  - LSH 0001: {sc_o,rslt} = {inA,sc_i}.
  - RSH 0010: {rslt,sc_o} = {sc_i,inA}.
  - MOV 0011: rslt = inA; sc_o = 0.
  - OR 0100, XOR 0101, AND 0110: bitwise; sc_o = 0.
  - ADDI 0111: same as ADD.
  - NOP 1111: rslt = inA; sc_o = 0.
  - Undefined codes: rslt = 0, sc_o = 0. done still pulses.
- MUL 1000, unsigned W x W -> 2W:
  - At edge k: latch operands, clear accumulator, counter = W, go to RUN.
  - Each RUN edge performs one shift-add step.
  - After edge k+W: {rslt_hi,rslt} = product, sc_o = 0, done = 1, back to IDLE.
  - busy is high for exactly W cycles.
- SHLN 1001 / SHRN 1010, n = inB[CNT_W-1:0] clamped to W:
  - n = 0: single-cycle; rslt = inA, sc_o = 0.
  - n >= 1: RUN for n cycles, shifting one bit per edge; vacated bits filled with 0.
  - sc_o = last bit shifted out. n >= W gives rslt = 0, sc_o = inA[0] (SHRN) or inA[W-1] (SHLN).
- done is high for exactly one cycle per accepted start, never while busy=1 except on the final RUN edge's output cycle (busy falls as done rises).
- Outputs hold their values between done pulses.
- start asserted in the same cycle as done is accepted (back-to-back issue).
- zero and pari are computed from the final result only, never from intermediate RUN values.

Decomposition:
- alu_pkg: alu_op_t enum (4-bit opcodes above), state_t {IDLE,RUN}, localparams OP_MUL/OP_SHLN/OP_SHRN, function is_multicycle(op, n).
- Sub-module alu_comb_core (combinational, parametrised W): all single-cycle ops, producing {sc, rslt}.
- seq_alu owns the FSM, counter, MUL accumulator, shifter registers and flag registers.

Test Plan:
- Reset then W=8 ADD inA=8'hFF, inB=8'h01, sc_i=0, start: done after 1 edge, rslt=8'h00, sc_o=1, zero=1, pari=0.
- MUL inA=8'hFF, inB=8'hFF: busy=1 for 8 cycles; then done, rslt_hi=8'hFE, rslt=8'h01, zero=0, pari=1.
- SHLN inA=8'h81, inB=3: done after 3 RUN edges, rslt=8'h08, sc_o=0; SHRN inA=8'h81, inB=0: single-cycle, rslt=8'h81, sc_o=0.
- SHRN inA=8'h01, inB=9 (clamped to 8): rslt=8'h00, sc_o=1, zero=1 after 8 RUN edges.
- Second start pulsed mid-MUL with different operands: ignored; exactly one done, product of the original operands.
- reset asserted at RUN cycle 4 of a MUL: next cycle busy=0, all outputs 0, no done; a subsequent ADD 3+4 gives rslt=7 one edge after start.
